// File: rtl/line_clear_ctrl.sv
// Line-clear controller: scans the board bottom-up after a piece locks and
// strobes per-row shift-down pulses for every full row. Optional scoring: LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] cell_occ,
  output logic [ROWS-1:0]      advance,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          score
);

  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [2:0]       lines_q, lines_d;
  logic [ROWS-1:0]  row_full;
  logic             cur_full;

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_full[r] = &cell_occ[r*COLS +: COLS];
    end
  end

  assign cur_full = row_full[ptr_q];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lines_d = lines_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ptr_d   = PTR_TOP;
          lines_d = '0;
        end
      end
      SCAN: begin
        if (cur_full) begin
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      SHIFT: begin
        // Pointer is kept so the row that just moved down is rescanned.
        state_d = SCAN;
        if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lines_q <= lines_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock.
  always_comb begin
    advance = '0;
    if (state_q == SHIFT) begin
      for (int i = 0; i < ROWS; i++) begin
        advance[i] = (PTR_W'(i) <= ptr_q);
      end
    end
  end

  assign busy          = (state_q == SCAN) || (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [10:0] award;
  logic [16:0] score_sum;

  always_comb begin
    unique case (lines_q)
      3'd0:    award = 11'd0;
      3'd1:    award = 11'd40;
      3'd2:    award = 11'd100;
      3'd3:    award = 11'd300;
      default: award = 11'd1200;
    endcase
    score_sum = {1'b0, score_q} + {6'd0, award};
    score_d   = score_q;
    if ((state_q == SCAN) && (state_d == DONE)) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: a board model shifts rows on advance,
// and a procedural line-clear reference predicts the per-cycle trace.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [ROWS*COLS-1:0] cell_occ;
  logic [ROWS-1:0]      advance;
  logic                 busy;
  logic                 done;
  logic [2:0]           lines_cleared;
  logic [15:0]          score;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cell_occ      (cell_occ),
    .advance       (advance),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  always #5 clk = ~clk;

  logic [COLS-1:0] board  [ROWS];
  logic [COLS-1:0] mboard [ROWS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) cell_occ[r*COLS +: COLS] = board[r];
  end

  typedef struct packed {
    logic            busy;
    logic [ROWS-1:0] adv;
    logic            done;
  } step_t;

  step_t trace[$];
  int    n_assert  = 0;
  int    n_fail    = 0;
  int    exp_score = 0;
  int    exp_lines = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic b, input logic [ROWS-1:0] a, input logic d);
    step_t s;
    s.busy = b;
    s.adv  = a;
    s.done = d;
    return s;
  endfunction

  function automatic int award(input int lines);
    if (lines == 0) return 0;
    if (lines == 1) return 40;
    if (lines == 2) return 100;
    if (lines == 3) return 300;
    return 1200;
  endfunction

  // Reference: walk rows bottom-up; a full row costs a scan and a shift cycle
  // and is rescanned, a non-full row costs one scan cycle.
  task automatic build_trace(output int lines);
    int  p;
    bool_loop: begin end
    trace.delete();
    lines  = 0;
    mboard = board;
    p      = ROWS - 1;
    for (int guard = 0; guard < 4*ROWS; guard++) begin
      if (mboard[p] == {COLS{1'b1}}) begin
        trace.push_back(mk(1'b1, '0, 1'b0));
        trace.push_back(mk(1'b1, ROWS'((64'd1 << (p + 1)) - 64'd1), 1'b0));
        for (int r = p; r > 0; r--) mboard[r] = mboard[r-1];
        mboard[0] = '0;
        lines++;
      end else begin
        trace.push_back(mk(1'b1, '0, 1'b0));
        if (p == 0) break;
        p--;
      end
    end
    trace.push_back(mk(1'b0, '0, 1'b1));
  endtask

  task automatic apply_advance(input logic [ROWS-1:0] adv);
    for (int r = ROWS - 1; r > 0; r--) if (adv[r]) board[r] = board[r-1];
    if (adv[0]) board[0] = '0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) board[r] = '0;
  endtask

  task automatic run_scan(input int hold, input string tag);
    int    lines;
    step_t s;
    build_trace(lines);
    exp_lines = (lines > 7) ? 7 : lines;
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + award(lines);
    if (exp_score > 65535) exp_score = 65535;
`endif
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= trace.size(); k++) begin
      @(negedge clk);
      s = trace[k-1];
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, s.busy});
      check({tag, ".advance"}, {12'd0, advance}, {12'd0, s.adv});
      check({tag, ".done"}, {31'd0, done}, {31'd0, s.done});
      if (s.done) begin
        check({tag, ".lines"}, {29'd0, lines_cleared}, exp_lines);
        check({tag, ".score"}, {16'd0, score}, exp_score);
      end
      if (advance != '0) apply_advance(advance);
      start = (k < hold);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, ".idle_busy"}, {31'd0, busy}, 0);
    check({tag, ".idle_done"}, {31'd0, done}, 0);
    check({tag, ".idle_adv"}, {12'd0, advance}, 0);
    check({tag, ".hold_lines"}, {29'd0, lines_cleared}, exp_lines);
    for (int r = 0; r < ROWS; r++) begin
      check($sformatf("%s.row%0d", tag, r), {22'd0, board[r]}, {22'd0, mboard[r]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    clear_board();

    // Reset state, observed with no clock edge involved.
    #1;
    check("rst.advance", {12'd0, advance}, 0);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.done", {31'd0, done}, 0);
    check("rst.lines", {29'd0, lines_cleared}, 0);
    check("rst.score", {16'd0, score}, 0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    run_scan(1, "empty");

    clear_board();
    board[19] = '1;
    run_scan(1, "row19");

    clear_board();
    for (int r = 16; r < 20; r++) board[r] = '1;
    board[15] = 10'h001;
    run_scan(1, "four");

    clear_board();
    board[10] = '1;
    board[12] = '1;
    board[11] = 10'h2F5;
    run_scan(1, "split");

    for (int r = 0; r < ROWS; r++) board[r] = '1;
    run_scan(1, "allfull");

    clear_board();
    board[19] = '1;
    board[18] = 10'h3FE;
    board[17] = '1;
    run_scan(6, "hold");

    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0:       board[r] = '1;
          1:       board[r] = '0;
          default: board[r] = COLS'($urandom);
        endcase
      end
      run_scan(1 + int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end

    // Abort during the second shift pulse.
    clear_board();
    board[18] = '1;
    board[19] = '1;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (advance != '0) begin
        pulses++;
        if (pulses == 2) break;
        apply_advance(advance);
      end
    end
    check("abort.second_pulse", pulses, 2);
    check("abort.lines_before", {29'd0, lines_cleared}, 1);
    reset = 1'b0;
    #1;
    check("abort.advance", {12'd0, advance}, 0);
    check("abort.busy", {31'd0, busy}, 0);
    check("abort.done", {31'd0, done}, 0);
    check("abort.lines", {29'd0, lines_cleared}, 0);
    check("abort.score", {16'd0, score}, 0);
    exp_score = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_scan(1, "post_rst");

    // Repeated four-line clears push the score past its ceiling.
    for (int t = 0; t < 56; t++) begin
      clear_board();
      for (int r = 16; r < 20; r++) board[r] = '1;
      run_scan(1, $sformatf("sat%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 Parameter ROWS, default 20, board height; row 0 is top, row ROWS-1 is bottom.
REQ-002 Parameter COLS, default 10, board width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the only reset.
REQ-005 start  input  1  one-cycle request to scan the board after a piece locks.
REQ-006 cell_occ  input  ROWS*COLS  per-cell occupied flags; bit r*COLS+c is row r, column c.
REQ-007 advance  output  ROWS  per-row shift-down strobe; bit r drives advance of every cell in row r.
REQ-008 busy  output  1  high while a scan is in progress; upstream SHALL NOT assert cell writes while busy.
REQ-009 done  output  1  one-cycle pulse when a scan completes.
REQ-010 lines_cleared  output  3  number of rows removed by the last scan, saturating at 7.
REQ-011 score  output  16  accumulated score (see Configuration).

Function
REQ-012 FSM states are IDLE, SCAN, SHIFT and DONE; busy is high in SCAN and SHIFT only.
REQ-013 In IDLE, start high at a clock edge loads row pointer = ROWS-1, clears lines_cleared to 0, and enters SCAN; start in any other state is ignored.
REQ-014 In SCAN, the row is full when all COLS bits of the current row in cell_occ are 1; this is evaluated combinationally in the same cycle.
REQ-015 SCAN with a full row goes to SHIFT and keeps the row pointer.
REQ-016 SCAN with a non-full row at pointer 0 goes to DONE; otherwise the pointer decrements and the FSM stays in SCAN.
REQ-017 In SHIFT, advance[i] = 1 for all i <= pointer and 0 for i > pointer, for exactly one cycle; advance is 0 in all other states.
REQ-018 SHIFT increments lines_cleared (saturating at 7) and returns to SCAN at the same pointer, so the row that moved down is rescanned.
REQ-019 Row 0 refills with empty cells; the upstream tie of row 0's prev input to zero is outside this block.
REQ-020 DONE asserts done for one cycle and returns to IDLE; lines_cleared holds until the next accepted start.
REQ-021 Latency: each non-full row costs 1 cycle, each cleared row costs 2 cycles (SCAN + SHIFT), and DONE adds 1 cycle.

Reset
REQ-022 While reset is low: the FSM is in IDLE, the pointer is 0, and advance, busy, done, lines_cleared and score are all 0, immediately and independent of clk.
REQ-023 Reset asserted mid-scan aborts the scan with no further advance pulse; partially shifted board contents are left as they are.

Configuration
REQ-024 With macro LINE_CLEAR_SCORE_EN defined, on entering DONE score adds 0/40/100/300/1200 for lines_cleared = 0/1/2/3/>=4 respectively, saturating at 65535.
REQ-025 Without LINE_CLEAR_SCORE_EN, score is held at 0, no score register is synthesised, and all other behaviour is identical.

Verification
REQ-026 Empty board, start pulse at edge E0 -> busy high for 20 cycles, done pulse in cycle 21, advance never asserted, lines_cleared = 0.
REQ-027 Row 19 full, others empty -> one advance pulse = 20'hFFFFF, then rows 19..0 are scanned, done pulses, lines_cleared = 1, score = 40 (macro on).
REQ-028 Rows 16..19 full, row 15 with one cell set -> four consecutive SHIFT pulses at pointer 19, each = 20'hFFFFF; lines_cleared = 4; score = 1200 (macro on) or 0 (macro off).
REQ-029 Rows 10 and 12 full, row 11 partial -> advance pulses with bits 12..0 set, then bits 11..0 set; lines_cleared = 2; done pulse 24 cycles after start.
REQ-030 Reset driven low during SHIFT -> advance, busy and lines_cleared drop to 0 without a clock edge; start after reset release -> normal scan.
REQ-031 Start re-asserted while busy -> ignored; exactly one done pulse; score saturates when preloaded near 65535 with 1200 added.
